wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
//  Two-master, one-slave Wishbone arbiter that shares a single slave port (RAM or bridge) between masters m0 and m1.
//  - Round-robin grant, held for a whole bus cycle (while the owner holds cyc); no preemption.
//  - Optional watchdog terminates stalled accesses with err.
//  - Sits between the bench/bridge masters and the wb slave model.
// PARAMETERS
//  DWIDTH   16  data width (8 or 16); sel width = DWIDTH/8
//  AWIDTH   8   address width
//  TIMEOUT  0   max wait cycles for slave ack/err/rty; 0 = watchdog disabled
//  TW       8   watchdog counter width; TIMEOUT must be < 2**TW
// PORTS
//  clk_i        in   1          single clock, rising edge
//  rst_i        in   1          synchronous reset, active high
//  mN_cyc_i     in   1          master N (N=0,1) cycle request
//  mN_stb_i     in   1          master N strobe
//  mN_we_i      in   1          master N write enable
//  mN_sel_i     in   DWIDTH/8   master N byte selects
//  mN_adr_i     in   AWIDTH     master N address
//  mN_dat_i     in   DWIDTH     master N write data
//  mN_dat_o     out  DWIDTH     read data = s_dat_i, broadcast to both masters
//  mN_ack_o     out  1          ack, routed to owner only
//  mN_err_o     out  1          err (slave err or watchdog), owner only
//  mN_rty_o     out  1          rty, owner only
//  s_cyc_o/s_stb_o/s_we_o  out  1  slave controls from owner
//  s_sel_o      out  DWIDTH/8   slave byte selects
//  s_adr_o      out  AWIDTH     slave address
//  s_dat_o      out  DWIDTH     slave write data
//  s_dat_i      in   DWIDTH     slave read data
//  s_ack_i/s_err_i/s_rty_i in 1 slave terminations
//  gnt_o        out  2          one-hot grant {m1,m0}; 2'b00 when idle
// BEHAVIOUR
//  Reset values
//  - rst_i sampled on clk_i forces state IDLE, last=1 (m0 preferred next), wdog=0.
//  - All s_* outputs, mN_ack/err/rty and gnt_o are 0. Reset mid-transfer aborts it; no termination is issued.
//  FSM states: IDLE, GNT0, GNT1
//  - IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
//  - IDLE, both requesting: grant the master != last; on entering GNTx, last <= x.
//  - GNTx: stay while mx_cyc_i=1; on mx_cyc_i=0 -> IDLE. Other master's requests are ignored.
//  - Grant latency: 1 clock from cyc seen in IDLE to gnt_o/s_cyc_o.
//  - Owner change always passes through 1 IDLE cycle.
//  Muxing (combinational from state)
//  - In GNTx: s_cyc_o=mx_cyc_i; s_stb_o=mx_stb_i & ~wd_err; s_we/sel/adr/dat = master x.
//  - In IDLE all s_* outputs are 0.
//  - mx_ack_o=s_ack_i, mx_rty_o=s_rty_i, mx_err_o=s_err_i|wd_err, each only in GNTx; 0 to the non-owner.
//  Watchdog (TIMEOUT>0 only; TIMEOUT=0 means wd_err is constant 0)
//  - wdog increments each clock s_cyc_o&s_stb_o&~(ack|err|rty).
//  - wdog clears on any termination, on stb low, or on state change.
//  - wd_err = (wdog==TIMEOUT), asserted for one cycle; wdog clears the next clock.
//  - Owner must drop stb after err; the grant is kept until owner cyc drops.
//  Simultaneous events
//  - Slave termination in the same cycle as wd_err: the slave termination is forwarded; err is OR'd in.
//  - Owner dropping cyc in the same cycle the other master raises cyc: IDLE next, then the other master is granted.
// TESTING
//  1. m0 writes 0xA55A @0x10, sel=11, slave ACK_DELAY=2 -> gnt_o=01 one clock later; m0_ack 2 clocks after stb.
//     m1_ack stays 0; an m0 read @0x10 returns 0xA55A.
//  2. m0 and m1 raise cyc the same clock after reset -> m0 granted first.
//     m0 drops cyc -> 1 IDLE cycle (gnt_o=00), then gnt_o=10.
//  3. m0 holds cyc over 3 back-to-back accesses while m1 requests -> gnt_o stays 01 for all three.
//     m1 is granted only after m0 cyc drops.
//  4. Both masters request continuously, one access per cycle -> grants alternate 01,10,01,10.
//  5. TIMEOUT=8, s_ack_i tied 0, m1 read -> m1_err_o pulses once, 8 clocks after s_stb_o rises.
//     s_stb_o is 0 in that cycle; m0_err_o stays 0.
//  6. rst_i pulsed while in GNT1 mid-access -> next clock s_cyc_o=0, gnt_o=00.
//     Both then request -> m0 granted first.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole
// bus cycle, with an optional watchdog that ends stalled accesses with err.
module wb_arbiter_2m #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 0,
  parameter int TW      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [DWIDTH/8-1:0]   m0_sel_i,
  input  logic [AWIDTH-1:0]     m0_adr_i,
  input  logic [DWIDTH-1:0]     m0_dat_i,
  output logic [DWIDTH-1:0]     m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [DWIDTH/8-1:0]   m1_sel_i,
  input  logic [AWIDTH-1:0]     m1_adr_i,
  input  logic [DWIDTH-1:0]     m1_dat_i,
  output logic [DWIDTH-1:0]     m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [DWIDTH/8-1:0]   s_sel_o,
  output logic [AWIDTH-1:0]     s_adr_o,
  output logic [DWIDTH-1:0]     s_dat_o,
  input  logic [DWIDTH-1:0]     s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;   // 1: m0 is preferred on the next tie
  logic   wd_err;

  // Read data is broadcast; only the owner ever sees a termination.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last) begin
            state_nxt = GNT0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = GNT1;
            last_nxt  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
          last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
          last_nxt  = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_nxt = IDLE;
      GNT1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output muxing, purely from state and the owner's inputs
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    gnt_o    = 2'b00;
    unique case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~wd_err;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_err;
        m0_rty_o = s_rty_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~wd_err;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_err;
        m1_rty_o = s_rty_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

  // Watchdog: counts stalled strobe cycles; wd_err masks stb for its one cycle,
  // which also drops the count condition so the counter clears the next clock.
  if (TIMEOUT > 0) begin : g_wdog
    logic [TW-1:0] wdog;
    logic          s_term;
    logic          wd_count;

    assign s_term   = s_ack_i | s_err_i | s_rty_i;
    assign wd_count = s_cyc_o & s_stb_o & ~s_term;
    assign wd_err   = (state != IDLE) && (wdog == TW'(TIMEOUT));

    always_ff @(posedge clk_i) begin
      if (rst_i || (state_nxt != state) || !wd_count) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + TW'(1);
      end
    end
  end else begin : g_no_wdog
    assign wd_err = 1'b0;
  end

  // Structural invariants
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_owner_via_idle : assert property (@(posedge clk_i) disable iff (rst_i)
    (state == GNT0) |=> (state != GNT1));
  a_owner_via_idle1 : assert property (@(posedge clk_i) disable iff (rst_i)
    (state == GNT1) |=> (state != GNT0));

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: two scripted masters, a RAM slave with a fixed
// two-clock ack delay, and per-master scoreboards of expected read data.
module tb_wb_arbiter_2m;

  localparam int DW        = 16;
  localparam int AW        = 8;
  localparam int ACK_DELAY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // master-side stimulus
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [1:0]    m_sel [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [DW-1:0] m_rdat[2];
  logic          m_ack [2];
  logic          m_err [2];
  logic          m_rty [2];

  // slave side
  logic          s_cyc, s_stb, s_we;
  logic [1:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic          s_ack, s_err, s_rty;
  logic [1:0]    gnt;

  wb_arbiter_2m #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(8), .TW(8)) dut (
    .clk_i   (clk),       .rst_i   (rst),
    .m0_cyc_i(m_cyc[0]),  .m0_stb_i(m_stb[0]), .m0_we_i (m_we[0]),
    .m0_sel_i(m_sel[0]),  .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
    .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m0_rty_o(m_rty[0]),
    .m1_cyc_i(m_cyc[1]),  .m1_stb_i(m_stb[1]), .m1_we_i (m_we[1]),
    .m1_sel_i(m_sel[1]),  .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
    .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .m1_rty_o(m_rty[1]),
    .s_cyc_o (s_cyc),     .s_stb_o (s_stb),    .s_we_o  (s_we),
    .s_sel_o (s_sel),     .s_adr_o (s_adr),    .s_dat_o (s_wdat),
    .s_dat_i (s_rdat),    .s_ack_i (s_ack),    .s_err_i (s_err),
    .s_rty_i (s_rty),     .gnt_o   (gnt)
  );

  // RAM slave: terminates ACK_DELAY clocks after stb is first seen
  logic [DW-1:0] mem [256];
  logic          s_trm;
  int            s_cnt;
  logic          slave_mute;
  int            term_kind;   // 0 ack, 1 err, 2 rty

  always @(posedge clk) begin
    if (rst) begin
      s_trm <= 1'b0;
      s_cnt <= 0;
    end else if (s_cyc && s_stb && !s_trm && !slave_mute) begin
      if (s_cnt == ACK_DELAY - 1) begin
        s_trm <= 1'b1;
        s_cnt <= 0;
        if (s_we && term_kind == 0)
          for (int b = 0; b < 2; b++)
            if (s_sel[b]) mem[s_adr][8*b +: 8] <= s_wdat[8*b +: 8];
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_trm <= 1'b0;
      s_cnt <= 0;
    end
  end

  assign s_ack  = s_trm && (term_kind == 0);
  assign s_err  = s_trm && (term_kind == 1);
  assign s_rty  = s_trm && (term_kind == 2);
  assign s_rdat = mem[s_adr];

  // reference memory and read-data scoreboards
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] sb_q0[$];
  logic [DW-1:0] sb_q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] gnt_tr  [64];
  logic       stb_tr  [64];
  logic       err0_tr [64];
  logic       err1_tr [64];

  // Records n cycles of observations, one per falling edge.
  task automatic sample_trace(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gnt_tr[i]  = gnt;
      stb_tr[i]  = s_stb;
      err0_tr[i] = m_err[0];
      err1_tr[i] = m_err[1];
    end
  endtask

  // One access by master m; called just after a rising edge. Returns the
  // cycle of termination and its kind (0 ack, 1 err, 2 rty, -1 none).
  task automatic do_access(input int m, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [1:0] sel,
                           input logic keep_cyc, output int term_cyc, output int term);
    logic          got;
    logic          stray;
    logic [DW-1:0] exp_d;
    got      = 1'b0;
    stray    = 1'b0;
    term     = -1;
    term_cyc = -1;
    if (we) begin
      for (int b = 0; b < 2; b++)
        if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
    end else if (m == 0) begin
      sb_q0.push_back(ref_mem[adr]);
    end else begin
      sb_q1.push_back(ref_mem[adr]);
    end
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat[m] = dat;  m_sel[m] = sel;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (m_ack[m] || m_err[m] || m_rty[m]) begin
        got      = 1'b1;
        term_cyc = cyc_cnt;
        term     = m_ack[m] ? 0 : (m_err[m] ? 1 : 2);
        stray    = m_ack[1-m] || m_err[1-m] || m_rty[1-m];
        if (!we) begin
          exp_d = (m == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
          if (term == 0) begin
            n_checks++;
            if (m_rdat[m] !== exp_d) begin
              n_fail++;
              $display("FAIL read_data m%0d @%h: got %h expected %h", m, adr, m_rdat[m], exp_d);
            end
          end
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL term_timeout m%0d @%h: no termination within 40 cycles", m, adr);
    end
    n_checks++;
    if (stray !== 1'b0) begin
      n_fail++;
      $display("FAIL non_owner_term m%0d: other master saw a termination (got %b expected 0)", m, stray);
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    if (!keep_cyc) m_cyc[m] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b cyc=%b stb=%b expected 00 0 0", gnt, s_cyc, s_stb);
    end
    n_checks++;
    if ({m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_terms: got %b expected 000000",
               {m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]});
    end
    @(posedge clk); #1;
    rst = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b expected 00", gnt);
    end
  endtask

  task automatic test_single();
    int start, ac, t, start2, ac2, t2;
    @(posedge clk); #1;
    start = cyc_cnt;
    fork
      do_access(0, 1'b1, 8'h10, 16'hA55A, 2'b11, 1'b1, ac, t);
      begin
        @(negedge clk);
        n_checks++;
        if (gnt !== 2'b00) begin
          n_fail++;
          $display("FAIL single_latency: got gnt=%b in request cycle expected 00", gnt);
        end
        @(negedge clk);
        n_checks++;
        if ({gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat} !==
            {2'b01, 1'b1, 1'b1, 1'b1, 2'b11, 8'h10, 16'hA55A}) begin
          n_fail++;
          $display("FAIL single_mux: got gnt=%b cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h expected 01 1 1 1 11 10 a55a",
                   gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat);
        end
      end
    join
    n_checks++;
    if (ac - start !== 3 || t !== 0) begin
      n_fail++;
      $display("FAIL single_ack_time: got %0d kind %0d expected 3 kind 0", ac - start, t);
    end
    start2 = cyc_cnt;
    do_access(0, 1'b0, 8'h10, 16'h0, 2'b11, 1'b0, ac2, t2);
    n_checks++;
    if (ac2 - start2 !== 2 || t2 !== 0) begin
      n_fail++;
      $display("FAIL held_read_time: got %0d kind %0d expected 2 kind 0", ac2 - start2, t2);
    end
  endtask

  task automatic test_tie_after_reset();
    int start, a0, a1, t0, t1;
    logic [1:0] exp_g [10];
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    pulse_reset();
    start = cyc_cnt;
    fork
      do_access(0, 1'b1, 8'h30, 16'h1234, 2'b11, 1'b0, a0, t0);
      do_access(1, 1'b0, 8'h10, 16'h0, 2'b11, 1'b0, a1, t1);
      sample_trace(10);
    join
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (gnt_tr[i] !== exp_g[i]) begin
        n_fail++;
        $display("FAIL tie_gnt[%0d]: got %b expected %b", i, gnt_tr[i], exp_g[i]);
      end
    end
    n_checks++;
    if (a0 - start !== 3 || a1 - start !== 8) begin
      n_fail++;
      $display("FAIL tie_ack_times: got m0=%0d m1=%0d expected m0=3 m1=8", a0 - start, a1 - start);
    end
  endtask

  task automatic test_hold_cycle();
    int start, a0, a1, a2, a3, t;
    logic [1:0] eg;
    @(posedge clk); #1;
    start = cyc_cnt;
    fork
      begin
        do_access(0, 1'b1, 8'h20, 16'h1111, 2'b11, 1'b1, a0, t);
        do_access(0, 1'b1, 8'h21, 16'h2222, 2'b01, 1'b1, a1, t);
        do_access(0, 1'b0, 8'h20, 16'h0,    2'b11, 1'b0, a2, t);
      end
      do_access(1, 1'b0, 8'h10, 16'h0, 2'b11, 1'b0, a3, t);
      sample_trace(15);
    join
    for (int i = 0; i < 15; i++) begin
      eg = (i == 0 || i == 11) ? 2'b00 : ((i <= 10) ? 2'b01 : 2'b10);
      n_checks++;
      if (gnt_tr[i] !== eg) begin
        n_fail++;
        $display("FAIL hold_gnt[%0d]: got %b expected %b", i, gnt_tr[i], eg);
      end
    end
    n_checks++;
    if (a0 - start !== 3 || a1 - start !== 6 || a2 - start !== 9 || a3 - start !== 14) begin
      n_fail++;
      $display("FAIL hold_ack_times: got %0d %0d %0d %0d expected 3 6 9 14",
               a0 - start, a1 - start, a2 - start, a3 - start);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] seq [8];
    logic [1:0] prev;
    int         n_seq;
    int         a, t;
    n_seq = 0;
    prev  = 2'b00;
    @(posedge clk); #1;
    fork
      for (int j = 0; j < 2; j++) begin
        do_access(0, 1'b1, AW'(8'h40 + j), 16'hC000 + DW'(j), 2'b11, 1'b0, a, t);
        @(posedge clk); #1;
      end
      for (int j = 0; j < 2; j++) begin
        do_access(1, 1'b1, AW'(8'h50 + j), 16'hD000 + DW'(j), 2'b11, 1'b0, a, t);
        @(posedge clk); #1;
      end
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (gnt != 2'b00 && gnt != prev && n_seq < 8) begin
          seq[n_seq] = gnt;
          n_seq++;
        end
        if (gnt != 2'b00) prev = gnt;
      end
    join
    n_checks++;
    if (n_seq !== 4) begin
      n_fail++;
      $display("FAIL alt_count: got %0d grant changes expected 4", n_seq);
    end
    for (int i = 0; i < 4 && i < n_seq; i++) begin
      n_checks++;
      if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL alt_gnt[%0d]: got %b expected %b", i, seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_err_rty_routing();
    int start, a, t;
    @(posedge clk); #1;
    term_kind = 1;
    start = cyc_cnt;
    do_access(0, 1'b0, 8'h10, 16'h0, 2'b11, 1'b0, a, t);
    n_checks++;
    if (t !== 1 || a - start !== 3) begin
      n_fail++;
      $display("FAIL err_route: got kind %0d at %0d expected kind 1 at 3", t, a - start);
    end
    @(posedge clk); #1;
    term_kind = 2;
    start = cyc_cnt;
    do_access(1, 1'b1, 8'h60, 16'h7777, 2'b11, 1'b0, a, t);
    n_checks++;
    if (t !== 2 || a - start !== 3) begin
      n_fail++;
      $display("FAIL rty_route: got kind %0d at %0d expected kind 2 at 3", t, a - start);
    end
    ref_mem[8'h60] = mem[8'h60];   // a retried write leaves memory untouched
    term_kind = 0;
  endtask

  task automatic test_watchdog();
    int start, a, t, n_err1, n_err0;
    @(posedge clk); #1;
    slave_mute = 1'b1;
    start = cyc_cnt;
    fork
      begin
        do_access(1, 1'b0, 8'h10, 16'h0, 2'b11, 1'b1, a, t);
        @(posedge clk); #1;
        @(posedge clk); #1 m_cyc[1] = 1'b0;
      end
      sample_trace(13);
    join
    slave_mute = 1'b0;
    n_checks++;
    if (t !== 1 || a - start !== 9) begin
      n_fail++;
      $display("FAIL wdog_err_time: got kind %0d at %0d expected kind 1 at 9", t, a - start);
    end
    n_err0 = 0;
    n_err1 = 0;
    for (int i = 0; i < 13; i++) begin
      n_err0 += int'(err0_tr[i]);
      n_err1 += int'(err1_tr[i]);
    end
    n_checks++;
    if (n_err1 !== 1 || n_err0 !== 0) begin
      n_fail++;
      $display("FAIL wdog_err_count: got m1=%0d m0=%0d expected m1=1 m0=0", n_err1, n_err0);
    end
    n_checks++;
    if (stb_tr[1] !== 1'b1 || stb_tr[8] !== 1'b1 || stb_tr[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_stb_mask: got stb[1]=%b stb[8]=%b stb[9]=%b expected 1 1 0",
               stb_tr[1], stb_tr[8], stb_tr[9]);
    end
    n_checks++;
    if (gnt_tr[10] !== 2'b10 || gnt_tr[11] !== 2'b10) begin
      n_fail++;
      $display("FAIL wdog_grant_kept: got %b %b expected 10 10", gnt_tr[10], gnt_tr[11]);
    end
  endtask

  task automatic test_reset_mid();
    int start, a0, a1, t0, t1;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 8'h10;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_pre_gnt: got %b expected 10", gnt);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_cyc !== 1'b0 || gnt !== 2'b00 || m_ack[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got cyc=%b gnt=%b ack=%b expected 0 00 0", s_cyc, gnt, m_ack[1]);
    end
    @(posedge clk); #1;
    start = cyc_cnt;
    fork
      do_access(0, 1'b0, 8'h10, 16'h0, 2'b11, 1'b0, a0, t0);
      do_access(1, 1'b0, 8'h30, 16'h0, 2'b11, 1'b0, a1, t1);
    join
    n_checks++;
    if (a0 - start !== 3 || a1 - start !== 8) begin
      n_fail++;
      $display("FAIL mid_regrant: got m0=%0d m1=%0d expected m0=3 m1=8", a0 - start, a1 - start);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_sel[m] = '0;   m_adr[m] = '0;   m_dat[m] = '0;
    end
    slave_mute = 1'b0;
    term_kind  = 0;
    test_reset();
    test_single();
    test_tie_after_reset();
    test_hold_cycle();
    test_alternate();
    test_err_rty_routing();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000");
    $fatal(1);
  end

endmodule
